fetch_stage: RTL and testbench

//  Instruction-fetch stage of the single-issue 32-bit CPU core.
//  - Owns the program counter and drives the byte address into the combinational
//    big-endian instruction memory.
//  - Captures the returned word into the IF/ID pipeline register for the decoder.
//  - Handles pipeline stall, branch/jump redirect with squash, and a sticky halt

---
 rtl/fetch_stage_pkg.sv | 29 ++
 rtl/fetch_stage_if.sv | 43 ++++
 rtl/fetch_stage_if_id_reg.sv | 39 +++
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: instruction width, reset/NOP constants,
// memory size and the control encodings used between the stage and IF/ID.
package fetch_stage_pkg;

  localparam int          INST_W         = 32;
  localparam logic [31:0] DEF_NOP_INST   = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
  localparam int          DEF_IMEM_BYTES = 100;

  // What the stage does on the coming edge, listed in priority order
  typedef enum logic [2:0] {
    FETCH_REDIRECT,
    FETCH_HALTED,
    FETCH_OVERRUN,
    FETCH_STALL,
    FETCH_NORMAL
  } fetch_op_e;

  typedef enum logic [1:0] {
    IFID_HOLD,
    IFID_LOAD,
    IFID_BUBBLE
  } ifid_ctrl_e;

  function automatic logic pc_in_range(input logic [31:0] pc, input int imem_bytes);
    return pc <= 32'(imem_bytes - 4);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, hazard/redirect inputs and the
// IF/ID outputs consumed by decode.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [31:0]       imem_addr;
  logic [INST_W-1:0] imem_inst;
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [INST_W-1:0] if_id_inst;
  logic [31:0]       if_id_pc4;
  logic              if_id_valid;
  logic              fetch_halt;
  logic [31:0]       fetch_count;

  modport master (
    output imem_addr,
    input  imem_inst,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output if_id_inst,
    output if_id_pc4,
    output if_id_valid,
    output fetch_halt,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_inst,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  if_id_inst,
    input  if_id_pc4,
    input  if_id_valid,
    input  fetch_halt,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: loads a fetched word, holds it, or replaces it
// with a bubble. A bubble keeps the previous pc4.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  ifid_ctrl_e        ctrl,
  input  logic [INST_W-1:0] inst_d,
  input  logic [31:0]       pc4_d,
  output logic [INST_W-1:0] inst_q,
  output logic [31:0]       pc4_q,
  output logic              valid_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= NOP_INST;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      case (ctrl)
        IFID_LOAD: begin
          inst_q  <= inst_d;
          pc4_q   <= pc4_d;
          valid_q <= 1'b1;
        end
        IFID_BUBBLE: begin
          inst_q  <= NOP_INST;
          valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, end-of-memory
// halt and fetched-instruction counter, feeding the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int          IMEM_BYTES = DEF_IMEM_BYTES,
  parameter logic [31:0] NOP_INST   = DEF_NOP_INST
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        halt_q;
  logic        halt_next;
  logic [31:0] count_q;
  logic [31:0] count_next;
  fetch_op_e   op;
  ifid_ctrl_e  ifid_ctrl;

  assign pc_plus4        = pc + 32'd4;
  assign redirect_target = bus.redirect_pc & ~32'h3;

  // Redirect outranks everything, including a sticky halt and a stall
  always_comb begin
    op = FETCH_NORMAL;
    if (bus.redirect_valid) begin
      op = FETCH_REDIRECT;
    end else if (halt_q) begin
      op = FETCH_HALTED;
    end else if (!pc_in_range(pc, IMEM_BYTES)) begin
      op = FETCH_OVERRUN;
    end else if (bus.stall) begin
      op = FETCH_STALL;
    end
  end

  always_comb begin
    pc_next    = pc;
    halt_next  = halt_q;
    count_next = count_q;
    ifid_ctrl  = IFID_HOLD;
    case (op)
      FETCH_REDIRECT: begin
        pc_next   = redirect_target;
        halt_next = 1'b0;
        ifid_ctrl = IFID_BUBBLE;
      end
      FETCH_OVERRUN: begin
        halt_next = 1'b1;
        ifid_ctrl = IFID_BUBBLE;
      end
      FETCH_NORMAL: begin
        pc_next    = pc_plus4;
        count_next = count_q + 32'd1;
        ifid_ctrl  = IFID_LOAD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      halt_q  <= 1'b0;
      count_q <= 32'h0;
    end else begin
      pc      <= pc_next;
      halt_q  <= halt_next;
      count_q <= count_next;
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .ctrl    (ifid_ctrl),
    .inst_d  (bus.imem_inst),
    .pc4_d   (pc_plus4),
    .inst_q  (bus.if_id_inst),
    .pc4_q   (bus.if_id_pc4),
    .valid_q (bus.if_id_valid)
  );

  assign bus.imem_addr   = pc;
  assign bus.fetch_halt  = halt_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: big-endian imem model, a reference
// model of the fetch priorities, and a scoreboard of expected IF/ID loads.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] LAST_PC = 32'd96;

  localparam logic [31:0] IMAGE [0:24] = '{
    32'h3408000B, 32'h34090008, 32'h012A5020, 32'h8D0B0000, 32'hADAC0004,
    32'h1109FFFA, 32'h21080001, 32'h08000003, 32'h3C0D1234, 32'h00011EF0,
    32'h35AD5678, 32'h01AE7022, 32'h000F7880, 32'h01F0C025, 32'h0311C82A,
    32'h13200002, 32'hAE190010, 32'h8E1A0010, 32'h0C000014, 32'h03E00008,
    32'h240A0001, 32'h254AFFFF, 32'h1540FFFE, 32'h00000000, 32'h34080000
  };

  logic clk;
  logic rst;
  fetch_stage_if bus ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks;
  int errors;

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_halt;
  logic [31:0] m_count;
  logic [31:0] seen_count;
  logic [63:0] sb [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = IMAGE[int'(a >> 2)];
    case (a[1:0])
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // Word assembled big-endian from four bytes; nothing beyond byte 99
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a > LAST_PC) return 32'h0;
    return {mem_byte(a), mem_byte(a + 1), mem_byte(a + 2), mem_byte(a + 3)};
  endfunction

  assign bus.imem_inst = mem_word(bus.imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_pc       = DEF_RESET_PC;
    m_inst     = DEF_NOP_INST;
    m_pc4      = 32'h0;
    m_valid    = 1'b0;
    m_halt     = 1'b0;
    m_count    = 32'h0;
    seen_count = 32'h0;
    sb.delete();
  endtask

  task automatic checkAgainstModel(input string phase);
    checkOutput({phase, "_addr"},  bus.imem_addr,   m_pc);
    checkOutput({phase, "_valid"}, bus.if_id_valid, m_valid);
    checkOutput({phase, "_halt"},  bus.fetch_halt,  m_halt);
    checkOutput({phase, "_count"}, bus.fetch_count, m_count);
    checkOutput({phase, "_inst"},  bus.if_id_inst,  m_inst);
    checkOutput({phase, "_pc4"},   bus.if_id_pc4,   m_pc4);
  endtask

  // Drive one edge's inputs, advance the reference model, then compare after the edge
  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc);
    logic [63:0] exp_load;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    if (rv) begin
      m_pc    = {rpc[31:2], 2'b00};
      m_valid = 1'b0;
      m_inst  = DEF_NOP_INST;
      m_halt  = 1'b0;
    end else if (m_halt) begin
    end else if (m_pc > LAST_PC) begin
      m_halt  = 1'b1;
      m_valid = 1'b0;
      m_inst  = DEF_NOP_INST;
    end else if (st) begin
    end else begin
      sb.push_back({mem_word(m_pc), m_pc + 32'd4});
      m_inst  = mem_word(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_count = m_count + 32'd1;
    end
    @(posedge clk);
    #1;
    checkAgainstModel("step");
    if (bus.fetch_count != seen_count) begin
      seen_count = bus.fetch_count;
      if (sb.size() > 0) begin
        exp_load = sb.pop_front();
        checkOutput("sb_inst", bus.if_id_inst, exp_load[63:32]);
        checkOutput("sb_pc4",  bus.if_id_pc4,  exp_load[31:0]);
      end else begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_addr"},  bus.imem_addr,   DEF_RESET_PC);
    checkOutput({tag, "_inst"},  bus.if_id_inst,  DEF_NOP_INST);
    checkOutput({tag, "_pc4"},   bus.if_id_pc4,   32'h0);
    checkOutput({tag, "_valid"}, bus.if_id_valid, 32'h0);
    checkOutput({tag, "_halt"},  bus.fetch_halt,  32'h0);
    checkOutput({tag, "_count"}, bus.fetch_count, 32'h0);
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    rst                = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    modelReset();

    // Reset release and first fetch
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t1_addr",  bus.imem_addr,   32'd4);
    checkOutput("t1_inst",  bus.if_id_inst,  32'h3408000B);
    checkOutput("t1_count", bus.fetch_count, 32'd1);

    // Stall holds PC and IF/ID
    applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t2_addr",  bus.imem_addr,   32'd8);
    checkOutput("t2_inst",  bus.if_id_inst,  32'h34090008);
    checkOutput("t2_pc4",   bus.if_id_pc4,   32'd8);
    checkOutput("t2_count", bus.fetch_count, 32'd2);

    // Misaligned redirect target is forced to a word boundary
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t3_pre_addr", bus.imem_addr, 32'd20);
    applyStimulus(1'b0, 1'b1, 32'h27);
    checkOutput("t3_addr",  bus.imem_addr,   32'd36);
    checkOutput("t3_valid", bus.if_id_valid, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t3_inst", bus.if_id_inst, 32'h00011EF0);
    checkOutput("t3_pc4",  bus.if_id_pc4,  32'd40);

    // Redirect beats a simultaneous stall
    applyStimulus(1'b1, 1'b1, 32'h0);
    checkOutput("t4_addr",  bus.imem_addr,   32'd0);
    checkOutput("t4_valid", bus.if_id_valid, 32'd0);

    // Last legal word, then sticky halt, then recovery by redirect
    for (int i = 0; i < 40 && m_pc != LAST_PC; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t5_last_inst",  bus.if_id_inst,  32'h34080000);
    checkOutput("t5_last_valid", bus.if_id_valid, 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t5_halt",  bus.fetch_halt,  32'd1);
    checkOutput("t5_valid", bus.if_id_valid, 32'd0);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t5_hold_addr", bus.imem_addr, 32'd100);
    applyStimulus(1'b0, 1'b1, 32'h0);
    checkOutput("t5_unhalt", bus.fetch_halt, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t5_resume_inst", bus.if_id_inst, 32'h3408000B);

    // Asynchronous reset pulse between edges
    rst = 1'b1;
    #1;
    rst = 1'b0;
    modelReset();
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t6_pre_count", bus.fetch_count, 32'd5);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("t6_async");
    #1;
    rst = 1'b0;
    modelReset();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t6_count", bus.fetch_count, 32'd1);

    // Random mix of stalls, redirects (some past the end of memory) and runs
    for (int i = 0; i < 120; i++) begin
      logic st;
      logic rv;
      st = ($urandom_range(0, 9) < 3);
      rv = ($urandom_range(0, 19) < 3);
      applyStimulus(st, rv, 32'($urandom_range(0, 127)));
    end
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
